ping_pong_line_fifo: RTL and testbench
======================================

Name: ping_pong_line_fifo

Overview:
Two-bank (ping-pong) line buffer between the sensor pixel capture path and the frame-FIFO-to-AXI-stream stage. The write side accepts one word per strobe, with start-of-frame and end-of-line markers. The read side presents a first-word-fall-through frame FIFO interface (ready / next_stb / sof / last / data). Each bank holds exactly one line. A bank becomes readable only when its line is complete.

Parameters:
DATA_WIDTH, 32, width of pixel word on both sides
ADDR_WIDTH, 12, log2 of words per bank (max line = 2^ADDR_WIDTH words)

Ports:
clk  in  1  single clock for both sides
rst  in  1  asynchronous, active-low reset
i_wr_stb  in  1  write one word this cycle
i_wr_sof  in  1  qualifies i_wr_stb; word is first word of a frame
i_wr_eol  in  1  qualifies i_wr_stb; word is last word of a line
i_wr_data  in  DATA_WIDTH  write word
o_wr_ready  out  1  a bank is free or currently being filled
o_overflow_stb  out  1  one-cycle pulse when a write word is dropped
o_frame_fifo_ready  out  1  o_frame_fifo_data/sof/last are valid
i_frame_fifo_next_stb  in  1  consume current word (honoured only when ready=1)
o_frame_fifo_sof  out  1  current word is first word of a frame
o_frame_fifo_last  out  1  current word is last word of its line
o_frame_fifo_data  out  DATA_WIDTH  current word

Behaviour:
- Reset (rst=0, async): both banks empty, wr_bank=0, rd_bank=0, read FSM IDLE. Outputs: o_frame_fifo_ready=0, sof=0, last=0, data=0, o_overflow_stb=0, o_wr_ready=1. A partially written line is discarded.
- Per-bank state: full flag, length (ADDR_WIDTH+1 bits, 1..2^ADDR_WIDTH), sof flag.
- Write side:
  - A word is stored at wr_addr in bank wr_bank only if that bank is not full; wr_addr then increments.
  - If i_wr_sof is set on the first word of a line (wr_addr=0), the bank's sof flag is set. i_wr_sof on any other word is ignored.
  - A stored word with i_wr_eol sets the bank's full flag and length=wr_addr+1 on that edge, clears wr_addr and toggles wr_bank.
  - Drop conditions, each pulsing o_overflow_stb for one cycle:
    - write strobe while wr_bank is full: word dropped.
    - write at wr_addr=2^ADDR_WIDTH (line too long): word dropped, no address wrap. A subsequent eol word is also dropped, but it still closes the line with length=2^ADDR_WIDTH.
  - o_wr_ready = ~full[wr_bank].
- Read FSM:
  - IDLE: if full[rd_bank], issue RAM read of address 0 and go to PRIME.
  - PRIME: RAM data returns (1-cycle synchronous RAM). Load output register, set ready=1, sof=bank sof flag, last=(length==1), go to STREAM.
  - STREAM: on next_stb with last=0, read address is advanced combinationally so the next word is valid the following cycle (sustained 1 word/cycle). sof=0 after word 0. last=1 on word length-1.
  - On next_stb with last=1: ready=0, and in the same edge clear full[rd_bank] and its sof flag, toggle rd_bank, go to IDLE.
- Latency: eol write at edge N → full set at N. IDLE detects at N+1, PRIME at N+2. o_frame_fifo_ready=1 after edge N+2 (2 cycles after the eol edge). Bank-to-bank gap on the read side is 2 idle cycles.
- Simultaneous events:
  - A read releasing bank B on the same edge the writer needs B: the write is dropped (full still set at that edge) and o_overflow_stb pulses. The writer sees B free on the next cycle.
  - An eol write and a read release of different banks on the same edge are both honoured.
- next_stb while ready=0 is ignored. Data/sof/last hold steady while ready=1 and next_stb=0.

Decomposition:
- Shared package ping_pong_line_fifo_pkg:
  - read FSM state encodings IDLE/PRIME/STREAM
  - NUM_BANKS=2 constant
  - bank-status record typedef (full, length, sof)
- One sub-module: ping_pong_line_ram, simple dual-port RAM of depth 2*2^ADDR_WIDTH with 1-cycle synchronous read. Bank select is the address MSB.

Test Plan:
- Reset, then write 4 words 0xA0..0xA3 with sof on word 0 and eol on word 3, holding next_stb=1 → ready rises 2 cycles after the eol edge. Reads A0(sof=1), A1, A2, A3(last=1) on consecutive cycles. Ready then drops.
- Write 2 lines of 3 words with next_stb=0 → o_wr_ready=0. A 7th write gives o_overflow_stb=1 and the word is absent from the output. Draining returns line 0 then line 1; sof=0 on line 1.
- Single-word line (sof+eol on one strobe, data 0x55) → one read with data=0x55, sof=1, last=1.
- ADDR_WIDTH=2, write a 6-word line → words 4 and 5 dropped with 2 overflow pulses. Read returns 4 words, last on word 3.
- Assert rst=0 mid-stream (ready=1, word 2 of 4) → ready/sof/last/data go 0 asynchronously, o_wr_ready=1. A fresh line after release reads correctly from bank 0.
- Toggle next_stb randomly 50% over 3 back-to-back lines → output word sequence is identical to input order, with no duplicates or losses.

Source files
------------

// File: rtl/ping_pong_line_fifo_pkg.sv
// Shared types and constants for the ping-pong line FIFO.
//   rd_state_e    : read-side FSM states
//   NUM_BANKS     : number of line banks
//   bank_status_t : per-bank full flag, stored line length and start-of-frame flag
package ping_pong_line_fifo_pkg;

    localparam int NUM_BANKS = 2;

    // Widest supported ADDR_WIDTH. Line lengths are carried at this width so the
    // record type does not depend on the instance parameter.
    localparam int unsigned MAX_ADDR_WIDTH = 16;
    localparam int unsigned LEN_W          = MAX_ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StPrime  = 2'd1,
        StStream = 2'd2
    } rd_state_e;

    typedef struct packed {
        logic             full;
        logic [LEN_W-1:0] length;
        logic             sof;
    } bank_status_t;

endpackage

// File: rtl/ping_pong_line_ram.sv
// Simple dual-port RAM holding both line banks; the address MSB selects the bank.
//   clk_i       : clock
//   wr_en_i     : write enable
//   wr_addr_i   : write address {bank, word}
//   wr_data_i   : write data
//   rd_en_i     : read enable; rd_data_o holds its value while low
//   rd_addr_i   : read address {bank, word}
//   rd_data_o   : read data, valid one cycle after rd_en_i
module ping_pong_line_ram #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic                  clk_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH:0]   wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH:0]   rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    localparam int unsigned Depth = 2 ** (ADDR_WIDTH + 1);

    logic [DATA_WIDTH-1:0] mem_q [Depth];
    logic [DATA_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/ping_pong_line_fifo.sv
// Two-bank line buffer between pixel capture and the frame-FIFO reader.
// Writer fills one bank per line; a bank becomes readable once its eol word lands.
// Reader is first-word-fall-through.
//   clk, rst                  : clock, asynchronous active-low reset
//   i_wr_stb/sof/eol/data     : write word with frame/line markers
//   o_wr_ready                : current write bank is not full
//   o_overflow_stb            : one-cycle pulse after a write word was dropped
//   o_frame_fifo_ready        : sof/last/data valid
//   i_frame_fifo_next_stb     : consume current word
//   o_frame_fifo_sof/last/data: current word and its markers
module ping_pong_line_fifo
    import ping_pong_line_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wr_stb,
    input  logic                  i_wr_sof,
    input  logic                  i_wr_eol,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic                  o_wr_ready,
    output logic                  o_overflow_stb,
    output logic                  o_frame_fifo_ready,
    input  logic                  i_frame_fifo_next_stb,
    output logic                  o_frame_fifo_sof,
    output logic                  o_frame_fifo_last,
    output logic [DATA_WIDTH-1:0] o_frame_fifo_data
);

    localparam logic [ADDR_WIDTH:0] LINE_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

    bank_status_t        bank_q [NUM_BANKS];
    bank_status_t        bank_d [NUM_BANKS];
    logic                wr_bank_q, wr_bank_d;
    logic                rd_bank_q, rd_bank_d;
    logic [ADDR_WIDTH:0] wr_addr_q, wr_addr_d;
    logic [ADDR_WIDTH:0] rd_idx_q, rd_idx_d;
    rd_state_e           state_q, state_d;
    logic                ready_q, ready_d;
    logic                out_sof_q, out_sof_d;
    logic                out_last_q, out_last_d;
    logic                ovf_q, ovf_d;

    logic                  ram_we, ram_re;
    logic [ADDR_WIDTH:0]   ram_waddr, ram_raddr;
    logic [DATA_WIDTH-1:0] ram_rdata;

    logic             line_done;
    logic [LEN_W-1:0] line_len;
    logic             set_sof;
    logic             release_bank;
    bank_status_t     rd_cur;

    assign rd_cur = bank_q[rd_bank_q];

    // Write side. Full status is the registered value, so a bank released on this
    // edge still rejects the word.
    always_comb begin
        wr_bank_d = wr_bank_q;
        wr_addr_d = wr_addr_q;
        ovf_d     = 1'b0;
        ram_we    = 1'b0;
        ram_waddr = {wr_bank_q, wr_addr_q[ADDR_WIDTH-1:0]};
        line_done = 1'b0;
        line_len  = '0;
        set_sof   = 1'b0;
        if (i_wr_stb) begin
            if (bank_q[wr_bank_q].full) begin
                ovf_d = 1'b1;
            end else if (wr_addr_q == LINE_MAX) begin
                // Line too long: drop, but an eol still closes the line.
                ovf_d = 1'b1;
                if (i_wr_eol) begin
                    line_done = 1'b1;
                    line_len  = LEN_W'(wr_addr_q);
                end
            end else begin
                ram_we    = 1'b1;
                wr_addr_d = wr_addr_q + 1'b1;
                set_sof   = i_wr_sof && (wr_addr_q == '0);
                if (i_wr_eol) begin
                    line_done = 1'b1;
                    line_len  = LEN_W'(wr_addr_q) + LEN_W'(1);
                end
            end
            if (line_done) begin
                wr_addr_d = '0;
                wr_bank_d = ~wr_bank_q;
            end
        end
    end

    // Read FSM. RAM output is the data register; it only updates on ram_re, so it
    // holds the current word while the consumer stalls.
    always_comb begin
        state_d      = state_q;
        rd_bank_d    = rd_bank_q;
        rd_idx_d     = rd_idx_q;
        ready_d      = ready_q;
        out_sof_d    = out_sof_q;
        out_last_d   = out_last_q;
        ram_re       = 1'b0;
        ram_raddr    = {rd_bank_q, rd_idx_q[ADDR_WIDTH-1:0]};
        release_bank = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (rd_cur.full) begin
                    ram_re    = 1'b1;
                    ram_raddr = {rd_bank_q, {ADDR_WIDTH{1'b0}}};
                    rd_idx_d  = '0;
                    state_d   = StPrime;
                end
            end
            StPrime: begin
                ready_d    = 1'b1;
                out_sof_d  = rd_cur.sof;
                out_last_d = (rd_cur.length == LEN_W'(1));
                state_d    = StStream;
            end
            StStream: begin
                if (i_frame_fifo_next_stb) begin
                    if (out_last_q) begin
                        ready_d      = 1'b0;
                        out_sof_d    = 1'b0;
                        out_last_d   = 1'b0;
                        release_bank = 1'b1;
                        rd_bank_d    = ~rd_bank_q;
                        state_d      = StIdle;
                    end else begin
                        rd_idx_d   = rd_idx_q + 1'b1;
                        ram_re     = 1'b1;
                        ram_raddr  = {rd_bank_q, rd_idx_d[ADDR_WIDTH-1:0]};
                        out_sof_d  = 1'b0;
                        out_last_d = (LEN_W'(rd_idx_q) + LEN_W'(2) == rd_cur.length);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Release and fill always target different banks, so both apply on one edge.
    always_comb begin
        for (int i = 0; i < NUM_BANKS; i++) begin
            bank_d[i] = bank_q[i];
        end
        if (release_bank) begin
            bank_d[rd_bank_q].full = 1'b0;
            bank_d[rd_bank_q].sof  = 1'b0;
        end
        if (set_sof) begin
            bank_d[wr_bank_q].sof = 1'b1;
        end
        if (line_done) begin
            bank_d[wr_bank_q].full   = 1'b1;
            bank_d[wr_bank_q].length = line_len;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_BANKS; i++) begin
                bank_q[i] <= '0;
            end
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            wr_addr_q  <= '0;
            rd_idx_q   <= '0;
            state_q    <= StIdle;
            ready_q    <= 1'b0;
            out_sof_q  <= 1'b0;
            out_last_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_BANKS; i++) begin
                bank_q[i] <= bank_d[i];
            end
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            wr_addr_q  <= wr_addr_d;
            rd_idx_q   <= rd_idx_d;
            state_q    <= state_d;
            ready_q    <= ready_d;
            out_sof_q  <= out_sof_d;
            out_last_q <= out_last_d;
            ovf_q      <= ovf_d;
        end
    end

    ping_pong_line_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk_i     (clk),
        .wr_en_i   (ram_we),
        .wr_addr_i (ram_waddr),
        .wr_data_i (i_wr_data),
        .rd_en_i   (ram_re),
        .rd_addr_i (ram_raddr),
        .rd_data_o (ram_rdata)
    );

    assign o_wr_ready         = ~bank_q[wr_bank_q].full;
    assign o_overflow_stb     = ovf_q;
    assign o_frame_fifo_ready = ready_q;
    assign o_frame_fifo_sof   = out_sof_q;
    assign o_frame_fifo_last  = out_last_q;
    // Gate the unreset RAM register so data reads as zero whenever not ready.
    assign o_frame_fifo_data  = ready_q ? ram_rdata : '0;

endmodule

// File: tb/tb_ping_pong_line_fifo.sv
module tb_ping_pong_line_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    // Main instance (ADDR_WIDTH=12)
    logic        wr_stb = 0, wr_sof = 0, wr_eol = 0;
    logic [31:0] wr_data = '0;
    logic        next_stb = 0;
    logic        wr_ready, ovf, ready, sof, last;
    logic [31:0] data;

    // Small instance (ADDR_WIDTH=2)
    logic        s_wr_stb = 0, s_wr_sof = 0, s_wr_eol = 0;
    logic [31:0] s_wr_data = '0;
    logic        s_next_stb = 0;
    logic        s_wr_ready, s_ovf, s_ready, s_sof, s_last;
    logic [31:0] s_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ping_pong_line_fifo #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .i_wr_stb              (wr_stb),
        .i_wr_sof              (wr_sof),
        .i_wr_eol              (wr_eol),
        .i_wr_data             (wr_data),
        .o_wr_ready            (wr_ready),
        .o_overflow_stb        (ovf),
        .o_frame_fifo_ready    (ready),
        .i_frame_fifo_next_stb (next_stb),
        .o_frame_fifo_sof      (sof),
        .o_frame_fifo_last     (last),
        .o_frame_fifo_data     (data)
    );

    ping_pong_line_fifo #(.DATA_WIDTH(32), .ADDR_WIDTH(2)) dut_s (
        .clk                   (clk),
        .rst                   (rst),
        .i_wr_stb              (s_wr_stb),
        .i_wr_sof              (s_wr_sof),
        .i_wr_eol              (s_wr_eol),
        .i_wr_data             (s_wr_data),
        .o_wr_ready            (s_wr_ready),
        .o_overflow_stb        (s_ovf),
        .o_frame_fifo_ready    (s_ready),
        .i_frame_fifo_next_stb (s_next_stb),
        .o_frame_fifo_sof      (s_sof),
        .o_frame_fifo_last     (s_last),
        .o_frame_fifo_data     (s_data)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic s, input logic e, input logic [31:0] d);
        wr_stb = 1; wr_sof = s; wr_eol = e; wr_data = d;
        tick();
        wr_stb = 0; wr_sof = 0; wr_eol = 0;
    endtask

    task automatic wr_s(input logic s, input logic e, input logic [31:0] d);
        s_wr_stb = 1; s_wr_sof = s; s_wr_eol = e; s_wr_data = d;
        tick();
        s_wr_stb = 0; s_wr_sof = 0; s_wr_eol = 0;
    endtask

    // Check {ready, sof, last, data} of the main instance.
    task automatic chk_out(input string tag, input logic r, input logic s, input logic l,
                           input logic [31:0] d);
        chk(tag, {29'd0, ready, sof, last, data}, {29'd0, r, s, l, d});
    endtask

    task automatic chk_s_out(input string tag, input logic r, input logic s, input logic l,
                             input logic [31:0] d);
        chk(tag, {29'd0, s_ready, s_sof, s_last, s_data}, {29'd0, r, s, l, d});
    endtask

    logic [31:0] got_d [$];
    logic [1:0]  got_f [$];
    int          wi, cyc, ovf_cnt;

    initial begin
        // ---- Reset values
        #1;
        chk_out("rst_out", 0, 0, 0, 32'h0);
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_ovf", ovf, 0);
        #11 rst = 1;
        tick();

        // ---- Test 1: 4-word line, next_stb held high
        next_stb = 1;
        wr(1, 0, 32'hA0);
        wr(0, 0, 32'hA1);
        wr(0, 0, 32'hA2);
        wr(0, 1, 32'hA3);
        chk("t1_ready_n", ready, 0);
        tick();
        chk("t1_ready_n1", ready, 0);
        tick();
        chk_out("t1_w0", 1, 1, 0, 32'hA0);
        tick();
        chk_out("t1_w1", 1, 0, 0, 32'hA1);
        tick();
        chk_out("t1_w2", 1, 0, 0, 32'hA2);
        tick();
        chk_out("t1_w3", 1, 0, 1, 32'hA3);
        tick();
        chk_out("t1_done", 0, 0, 0, 32'h0);
        next_stb = 0;

        // ---- Test 2: two lines fill both banks, then an overflow
        wr(1, 0, 32'hB0);
        wr(0, 0, 32'hB1);
        wr(0, 1, 32'hB2);
        wr(0, 0, 32'hC0);
        wr(0, 0, 32'hC1);
        wr(0, 1, 32'hC2);
        chk("t2_wr_ready_full", wr_ready, 0);
        chk("t2_ovf_before", ovf, 0);
        wr(0, 0, 32'hDD);
        chk("t2_ovf_pulse", ovf, 1);
        tick();
        chk("t2_ovf_clear", ovf, 0);
        chk_out("t2_b0_stall", 1, 1, 0, 32'hB0);
        next_stb = 1;
        tick();
        chk_out("t2_b1", 1, 0, 0, 32'hB1);
        tick();
        chk_out("t2_b2", 1, 0, 1, 32'hB2);
        tick();
        chk_out("t2_gap0", 0, 0, 0, 32'h0);
        chk("t2_wr_ready_free", wr_ready, 1);
        tick();
        chk_out("t2_gap1", 0, 0, 0, 32'h0);
        tick();
        chk_out("t2_c0", 1, 0, 0, 32'hC0);
        tick();
        chk_out("t2_c1", 1, 0, 0, 32'hC1);
        tick();
        chk_out("t2_c2", 1, 0, 1, 32'hC2);
        tick();
        chk_out("t2_done", 0, 0, 0, 32'h0);
        tick();
        tick();
        chk("t2_no_dropped_word", ready, 0);
        next_stb = 0;

        // ---- Test 3: single-word line
        wr(1, 1, 32'h55);
        tick();
        tick();
        chk_out("t3_single", 1, 1, 1, 32'h55);
        tick();
        chk_out("t3_hold", 1, 1, 1, 32'h55);
        next_stb = 1;
        tick();
        chk_out("t3_done", 0, 0, 0, 32'h0);
        next_stb = 0;

        // ---- Test 4: ADDR_WIDTH=2, 6-word line truncated to 4
        wr_s(1, 0, 32'hD0);
        wr_s(0, 0, 32'hD1);
        wr_s(0, 0, 32'hD2);
        wr_s(0, 0, 32'hD3);
        chk("t4_ovf_w3", s_ovf, 0);
        wr_s(0, 0, 32'hD4);
        chk("t4_ovf_w4", s_ovf, 1);
        wr_s(0, 1, 32'hD5);
        chk("t4_ovf_w5", s_ovf, 1);
        s_next_stb = 1;
        tick();
        chk("t4_ovf_end", s_ovf, 0);
        chk("t4_ready_n1", s_ready, 0);
        tick();
        chk_s_out("t4_w0", 1, 1, 0, 32'hD0);
        tick();
        chk_s_out("t4_w1", 1, 0, 0, 32'hD1);
        tick();
        chk_s_out("t4_w2", 1, 0, 0, 32'hD2);
        tick();
        chk_s_out("t4_w3", 1, 0, 1, 32'hD3);
        tick();
        chk_s_out("t4_done", 0, 0, 0, 32'h0);
        s_next_stb = 0;

        // ---- Test 5: asynchronous reset mid-stream
        wr(1, 0, 32'hE0);
        wr(0, 0, 32'hE1);
        wr(0, 0, 32'hE2);
        wr(0, 1, 32'hE3);
        tick();
        tick();
        chk_out("t5_e0", 1, 1, 0, 32'hE0);
        next_stb = 1;
        tick();
        tick();
        chk_out("t5_e2", 1, 0, 0, 32'hE2);
        next_stb = 0;
        rst = 0;
        #1;
        chk_out("t5_async_rst", 0, 0, 0, 32'h0);
        chk("t5_rst_wr_ready", wr_ready, 1);
        @(negedge clk);
        rst = 1;
        tick();
        next_stb = 1;
        wr(1, 0, 32'hF0);
        wr(0, 0, 32'hF1);
        wr(0, 1, 32'hF2);
        tick();
        tick();
        chk_out("t5_f0", 1, 1, 0, 32'hF0);
        tick();
        chk_out("t5_f1", 1, 0, 0, 32'hF1);
        tick();
        chk_out("t5_f2", 1, 0, 1, 32'hF2);
        tick();
        chk_out("t5_done", 0, 0, 0, 32'h0);
        next_stb = 0;

        // ---- Test 6: three back-to-back lines, random consumer
        wi = 0;
        cyc = 0;
        ovf_cnt = 0;
        while (got_d.size() < 12 && cyc < 600) begin
            next_stb = 1'($urandom_range(0, 1));
            if (wi < 12 && wr_ready) begin
                wr_stb  = 1;
                wr_sof  = (wi == 0);
                wr_eol  = (wi % 4 == 3);
                wr_data = 32'hC000 + 32'(wi);
                wi++;
            end else begin
                wr_stb = 0; wr_sof = 0; wr_eol = 0;
            end
            if (ready && next_stb) begin
                got_d.push_back(data);
                got_f.push_back({sof, last});
            end
            tick();
            cyc++;
            if (ovf) ovf_cnt++;
        end
        wr_stb = 0; wr_sof = 0; wr_eol = 0; next_stb = 0;
        chk("t6_count", 64'(got_d.size()), 12);
        chk("t6_ovf_cnt", 64'(ovf_cnt), 0);
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("t6_data%0d", i),
                (i < got_d.size()) ? {32'd0, got_d[i]} : 64'hx,
                64'h0000C000 + 64'(i));
            chk($sformatf("t6_flags%0d", i),
                (i < got_f.size()) ? {62'd0, got_f[i]} : 64'hx,
                {62'd0, (i == 0), (i % 4 == 3)});
        end
        tick();
        chk("t6_idle", ready, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
